stq_id_alloc: RTL

- Allocates store-queue IDs (stqid) in program order at dispatch (rs0). Consumed by the store queue via the issue packet's mem stqid field.
- Circular head/tail allocator with wrap bits.
  - Head frees on in-order store commit.
  - Tail rolls back on pipeline nuke.
- Sits between dispatch and the store queue. Drives the full/stall signal back to dispatch.

---
 rtl/stq_id_alloc_pkg.sv | 37 +++
 rtl/stq_id_alloc_nuke_scan.sv | 30 +++
 rtl/stq_id_alloc.sv | 126 ++++++++++++
 3 files changed

// File: rtl/stq_id_alloc_pkg.sv
// Shared store-queue types and ROB-ID age helpers for the stqid allocator.
// Used by stq_id_alloc (optional watermark: STQ_ALLOC_WATERMARK_EN).
package mem_defs;

    localparam int STQ_NUM_ENTRIES = 8;
    localparam int STQ_ID_W        = $clog2(STQ_NUM_ENTRIES);

    typedef logic [STQ_ID_W-1:0] t_stq_id;
    typedef logic [STQ_ID_W:0]   t_stq_ptr;

endpackage

package gen_funcs;

    localparam int ROBID_MAX_W = 16;

    // Age relative to the oldest ROB entry, so wrapped robids order correctly.
    function automatic logic [ROBID_MAX_W-1:0] rob_age(
        input logic [ROBID_MAX_W-1:0] x,
        input logic [ROBID_MAX_W-1:0] oldest,
        input int                     w
    );
        logic [ROBID_MAX_W-1:0] mask;
        mask = (ROBID_MAX_W'(1) << w) - ROBID_MAX_W'(1);
        return (x - oldest) & mask;
    endfunction

    function automatic logic rob_younger_eq(
        input logic [ROBID_MAX_W-1:0] x,
        input logic [ROBID_MAX_W-1:0] ref_id,
        input logic [ROBID_MAX_W-1:0] oldest,
        input int                     w
    );
        return rob_age(x, oldest, w) >= rob_age(ref_id, oldest, w);
    endfunction

endpackage

// File: rtl/stq_id_alloc_nuke_scan.sv
// Find-first flushed entry, scanning from head in allocation order.
// Returns the pointer (with wrap bit) of that entry and a found flag.
module stq_nuke_scan #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic [NUM_ENTRIES-1:0]          flush_i,
    input  logic [$clog2(NUM_ENTRIES):0]    head_ptr_i,
    output logic [$clog2(NUM_ENTRIES):0]    new_tail_o,
    output logic                            found_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] ptr;

    always_comb begin
        found_o    = 1'b0;
        new_tail_o = head_ptr_i;
        ptr        = head_ptr_i;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ptr = head_ptr_i + PTR_W'(i);
            if (!found_o && flush_i[ptr[IDX_W-1:0]]) begin
                found_o    = 1'b1;
                new_tail_o = ptr;
            end
        end
    end

endmodule

// File: rtl/stq_id_alloc.sv
// Store-queue ID allocator: circular head/tail with wrap bits, nuke rollback.
// STQ_ALLOC_WATERMARK_EN builds the almost-full watermark output.
module stq_id_alloc
    import mem_defs::*;
    import gen_funcs::*;
#(
    parameter int NUM_ENTRIES = STQ_NUM_ENTRIES,
    parameter int ROBID_W     = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           disp_valid_rs0,
    input  logic                           disp_is_st_rs0,
    input  logic [ROBID_W-1:0]             disp_robid_rs0,
    output logic [$clog2(NUM_ENTRIES)-1:0] alloc_stqid_rs0,
    output logic                           stq_full_rs0,
    output logic                           stq_empty,
    output logic [$clog2(NUM_ENTRIES):0]   stq_count,
    output logic [$clog2(NUM_ENTRIES)-1:0] head_stqid,
    input  logic                           dealloc_valid_rt,
    input  logic                           nuke_valid_rb1,
    input  logic [ROBID_W-1:0]             nuke_robid_rb1,
    input  logic [ROBID_W-1:0]             oldest_robid,
    output logic                           stq_almost_full_rs0
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [NUM_ENTRIES-1:0] e_valid_q, e_valid_d;
    logic [ROBID_W-1:0]     e_robid_q [NUM_ENTRIES];
    logic [ROBID_W-1:0]     e_robid_d [NUM_ENTRIES];

    logic [PTR_W-1:0]       count;
    logic                   alloc;
    logic [NUM_ENTRIES-1:0] flush;
    logic [PTR_W-1:0]       scan_tail;
    logic                   scan_found;

    assign count = tail_q - head_q;
    assign alloc = disp_valid_rs0 & disp_is_st_rs0 & ~nuke_valid_rb1;

    assign alloc_stqid_rs0 = tail_q[IDX_W-1:0];
    assign head_stqid      = head_q[IDX_W-1:0];
    assign stq_count       = count;
    assign stq_full_rs0    = (count == PTR_W'(NUM_ENTRIES));
    assign stq_empty       = (count == '0);

`ifdef STQ_ALLOC_WATERMARK_EN
    assign stq_almost_full_rs0 = (PTR_W'(NUM_ENTRIES) - count) <= PTR_W'(2);
`else
    assign stq_almost_full_rs0 = 1'b0;
`endif

    always_comb begin
        flush = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            flush[i] = e_valid_q[i] & rob_younger_eq(
                ROBID_MAX_W'(e_robid_q[i]),
                ROBID_MAX_W'(nuke_robid_rb1),
                ROBID_MAX_W'(oldest_robid),
                ROBID_W);
        end
    end

    stq_nuke_scan #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_scan (
        .flush_i    (flush),
        .head_ptr_i (head_q),
        .new_tail_o (scan_tail),
        .found_o    (scan_found)
    );

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        e_valid_d = e_valid_q;
        e_robid_d = e_robid_q;
        if (nuke_valid_rb1) begin
            e_valid_d = e_valid_q & ~flush;
            if (scan_found) begin
                tail_d = scan_tail;
            end
        end
        if (dealloc_valid_rt) begin
            e_valid_d[head_q[IDX_W-1:0]] = 1'b0;
            head_d = head_q + PTR_W'(1);
            // A flushed head leaves tail at head; the commit drags it along.
            if (tail_d == head_q) begin
                tail_d = head_q + PTR_W'(1);
            end
        end
        if (alloc) begin
            e_valid_d[tail_q[IDX_W-1:0]] = 1'b1;
            e_robid_d[tail_q[IDX_W-1:0]] = disp_robid_rs0;
            tail_d = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            e_valid_q <= '0;
            e_robid_q <= '{default: '0};
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            e_valid_q <= e_valid_d;
            e_robid_q <= e_robid_d;
        end
    end

`ifdef SIMULATION
    a_no_alloc_full: assert property (@(posedge clk) disable iff (reset)
        !(alloc && stq_full_rs0 && !dealloc_valid_rt))
        else $error("stq_id_alloc: store allocated while full");
    a_no_dealloc_empty: assert property (@(posedge clk) disable iff (reset)
        !(dealloc_valid_rt && stq_empty))
        else $error("stq_id_alloc: dealloc while empty");
`endif

endmodule
